// File: rtl/ycc_pkg.sv
// Shared types and fixed-point constants for the YCbCr <-> RGB colour converters.
package ycc_pkg;

  localparam int unsigned DCT_DATA_WIDTH = 10;

  typedef struct packed {
    logic [DCT_DATA_WIDTH-1:0] data;
    logic                      valid;
  } dct_port_t;

  localparam int unsigned COEF_FRAC  = 8;
  localparam int unsigned COEF_WIDTH = 12;

  // Real coefficients scaled by 2^COEF_FRAC, rounded to nearest
  localparam int KY   = 256;
  localparam int KRCR = 359;
  localparam int KGCB = -88;
  localparam int KGCR = -183;
  localparam int KBCB = 454;

  function automatic int unsigned off(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

  function automatic int unsigned prod_width(input int unsigned dw);
    return dw + 1 + COEF_WIDTH;
  endfunction

  // Three products plus the round constant need two extra bits of headroom
  function automatic int unsigned sum_width(input int unsigned dw);
    return prod_width(dw) + 2;
  endfunction

endpackage

// File: rtl/ycc_lane_mac.sv
// One output colour channel: coefficient products, rounded sum, shift and clamp (S2-S4).
module ycc_lane_mac
  import ycc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned COEF_FRAC  = 8,
  parameter int          KA         = 0,
  parameter int          KB         = 0,
  parameter int          KC         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic signed [DATA_WIDTH:0] cb,
  input  logic signed [DATA_WIDTH:0] cr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned PW = prod_width(DATA_WIDTH);
  localparam int unsigned SW = sum_width(DATA_WIDTH);
  localparam logic signed [SW-1:0] RND  = SW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** DATA_WIDTH - 1);

  logic signed [PW-1:0] y_ext, cb_ext, cr_ext;
  logic signed [PW-1:0] pa_q, pb_q, pc_q;
  logic signed [SW-1:0] sum_q, shifted;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  unused_operands;

  assign y_ext  = PW'($signed({1'b0, y}));
  assign cb_ext = PW'(cb);
  assign cr_ext = PW'(cr);
  // Pruned lanes leave some operands unread
  assign unused_operands = ^{y_ext, cb_ext, cr_ext};

  if (KA != 0) begin : g_pa
    localparam logic signed [PW-1:0] K = PW'(KA);
    always_ff @(posedge clk) pa_q <= y_ext * K;
  end else begin : g_pa_pruned
    assign pa_q = '0;
  end

  if (KB != 0) begin : g_pb
    localparam logic signed [PW-1:0] K = PW'(KB);
    always_ff @(posedge clk) pb_q <= cb_ext * K;
  end else begin : g_pb_pruned
    assign pb_q = '0;
  end

  if (KC != 0) begin : g_pc
    localparam logic signed [PW-1:0] K = PW'(KC);
    always_ff @(posedge clk) pc_q <= cr_ext * K;
  end else begin : g_pc_pruned
    assign pc_q = '0;
  end

  always_ff @(posedge clk) begin
    sum_q <= SW'(pa_q) + SW'(pb_q) + SW'(pc_q) + RND;
  end

  assign shifted = sum_q >>> COEF_FRAC;

  // Clamp on the full-width value so large sums never wrap
  always_comb begin
    data_d = shifted[DATA_WIDTH-1:0];
    if (shifted < 0) begin
      data_d = '0;
    end else if (shifted > MAXV) begin
      data_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= data_d;
    end
  end

endmodule

// File: rtl/ycbcr_to_rgb.sv
// Full-range YCbCr to RGB converter: 4-cycle fixed latency, one pixel per clock.
module ycbcr_to_rgb
  import ycc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ycc_pkg::DCT_DATA_WIDTH,
  parameter int unsigned COEF_FRAC  = ycc_pkg::COEF_FRAC
) (
  input  logic      clk,
  input  logic      rst_n,
  input  dct_port_t in  [3],
  output dct_port_t out [3],
  output logic      err_misalign
);

  localparam logic signed [DATA_WIDTH:0] OFF_S = (DATA_WIDTH + 1)'(off(DATA_WIDTH));

  logic                         in_valid, lanes_agree;
  logic [DATA_WIDTH-1:0]        y_q;
  logic signed [DATA_WIDTH:0]   cb_q, cr_q;
  logic [3:0]                   vld_q;
  logic [DATA_WIDTH-1:0]        lane_data [3];

  assign in_valid    = in[0].valid & in[1].valid & in[2].valid;
  assign lanes_agree = in_valid | ~(in[0].valid | in[1].valid | in[2].valid);

  always_ff @(posedge clk) begin
    y_q  <= in[0].data;
    cb_q <= $signed({1'b0, in[1].data}) - OFF_S;
    cr_q <= $signed({1'b0, in[2].data}) - OFF_S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      err_misalign <= 1'b0;
    end else begin
      vld_q <= {vld_q[2:0], in_valid};
      if (!lanes_agree) begin
        err_misalign <= 1'b1;
      end
    end
  end

  ycc_lane_mac #(
    .DATA_WIDTH(DATA_WIDTH), .COEF_FRAC(COEF_FRAC), .KA(KY), .KB(0), .KC(KRCR)
  ) u_mac_r (
    .clk(clk), .rst_n(rst_n), .y(y_q), .cb(cb_q), .cr(cr_q), .data(lane_data[0])
  );

  ycc_lane_mac #(
    .DATA_WIDTH(DATA_WIDTH), .COEF_FRAC(COEF_FRAC), .KA(KY), .KB(KGCB), .KC(KGCR)
  ) u_mac_g (
    .clk(clk), .rst_n(rst_n), .y(y_q), .cb(cb_q), .cr(cr_q), .data(lane_data[1])
  );

  ycc_lane_mac #(
    .DATA_WIDTH(DATA_WIDTH), .COEF_FRAC(COEF_FRAC), .KA(KY), .KB(KBCB), .KC(0)
  ) u_mac_b (
    .clk(clk), .rst_n(rst_n), .y(y_q), .cb(cb_q), .cr(cr_q), .data(lane_data[2])
  );

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      out[k].data  = lane_data[k];
      out[k].valid = vld_q[3];
    end
  end

endmodule
